// File: rtl/fetch_align_queue_if.sv
// Handshake bundle between fetch, the parcel queue and decode.
// The queue connects through the slave modport; the fetch/decode side uses master.
interface fetch_align_queue_if #(
    parameter int DEPTH = 8,
    parameter int PCW   = 32
);
    logic                     fetch_valid;
    logic [PCW-1:0]           fetch_pc;
    logic [31:0]              fetch_rdata;
    logic                     fetch_ready;
    logic                     clear;
    logic                     dec_stall;
    logic                     dec_ready;
    logic [PCW-1:0]           dec_pc;
    logic [31:0]              dec_instr;
    logic [PCW-1:0]           dec_npc;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output fetch_valid, fetch_pc, fetch_rdata, clear, dec_stall,
        input  fetch_ready, dec_ready, dec_pc, dec_instr, dec_npc, count
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_rdata, clear, dec_stall,
        output fetch_ready, dec_ready, dec_pc, dec_instr, dec_npc, count
    );
endinterface

// File: rtl/fetch_align_queue.sv
// Parcel queue between fetch and decode. Fetch words are split into 16-bit parcels
// held in a circular buffer; whole RV32 instructions (16 or 32 bit) are rebuilt at
// the head and presented to decode one per cycle.
module fetch_align_queue #(
    parameter int DEPTH    = 8,
    parameter int ENABLE_C = 1,
    parameter int PCW      = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    fetch_align_queue_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]    parcel_q [DEPTH];
    logic [15:0]    parcel_d [DEPTH];
    logic [PCW-1:0] pc_q     [DEPTH];
    logic [PCW-1:0] pc_d     [DEPTH];
    logic [AW-1:0]  wr_q, wr_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic [CW-1:0]  count_q, count_d;

    logic [AW-1:0]  wr_p1_s;
    logic [AW-1:0]  rd_p1_s;
    logic [15:0]    head_parcel_s;
    logic [15:0]    next_parcel_s;
    logic [PCW-1:0] head_pc_s;
    logic           is_long_s;
    logic           dec_ready_s;
    logic           fetch_ready_s;
    logic           push_s;
    logic           pop_s;
    logic [AW-1:0]  push_adv_s;
    logic [AW-1:0]  pop_adv_s;
    logic [CW-1:0]  push_cnt_s;
    logic [CW-1:0]  pop_cnt_s;
    logic [PCW-1:0] dec_pc_s;
    logic [31:0]    dec_instr_s;
    logic [PCW-1:0] dec_npc_s;

    // Head inspection and handshake qualification from the current queue state.
    always_comb begin
        wr_p1_s       = wr_q + AW'(1);
        rd_p1_s       = rd_q + AW'(1);
        head_parcel_s = parcel_q[rd_q];
        next_parcel_s = parcel_q[rd_p1_s];
        head_pc_s     = pc_q[rd_q];
        is_long_s     = (ENABLE_C == 0) || (head_parcel_s[1:0] == 2'b11);
        if (is_long_s) begin
            dec_ready_s = (count_q >= CW'(2));
        end else begin
            dec_ready_s = (count_q >= CW'(1));
        end
        // Room for a full word is required even for an upper-half-only push.
        fetch_ready_s = (count_q <= CW'(DEPTH - 2)) && !bus.clear;
        push_s        = bus.fetch_valid && fetch_ready_s;
        pop_s         = dec_ready_s && !bus.dec_stall && !bus.clear;
        push_adv_s    = bus.fetch_pc[1] ? AW'(1) : AW'(2);
        push_cnt_s    = bus.fetch_pc[1] ? CW'(1) : CW'(2);
        pop_adv_s     = is_long_s ? AW'(2) : AW'(1);
        pop_cnt_s     = is_long_s ? CW'(2) : CW'(1);
    end

    // Decode-facing view of the head; forced to zero when no whole instruction is held.
    always_comb begin
        dec_pc_s    = '0;
        dec_instr_s = 32'h0000_0000;
        dec_npc_s   = '0;
        if (dec_ready_s) begin
            dec_pc_s = head_pc_s;
            if (is_long_s) begin
                dec_instr_s = {next_parcel_s, head_parcel_s};
                dec_npc_s   = head_pc_s + PCW'(4);
            end else begin
                dec_instr_s = {16'h0000, head_parcel_s};
                dec_npc_s   = head_pc_s + PCW'(2);
            end
        end else begin
            dec_pc_s    = '0;
            dec_instr_s = 32'h0000_0000;
            dec_npc_s   = '0;
        end
    end

    // Next queue state: flush wins, otherwise push and pop apply together.
    always_comb begin
        parcel_d = parcel_q;
        pc_d     = pc_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        count_d  = count_q;
        if (bus.clear) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push_s) begin
                if (bus.fetch_pc[1]) begin
                    // Word fetched for an upper-half start: lower parcel is not on the path.
                    parcel_d[wr_q] = bus.fetch_rdata[31:16];
                    pc_d[wr_q]     = bus.fetch_pc;
                end else begin
                    parcel_d[wr_q]    = bus.fetch_rdata[15:0];
                    pc_d[wr_q]        = bus.fetch_pc;
                    parcel_d[wr_p1_s] = bus.fetch_rdata[31:16];
                    pc_d[wr_p1_s]     = bus.fetch_pc + PCW'(2);
                end
                wr_d = wr_q + push_adv_s;
            end else begin
                wr_d = wr_q;
            end
            if (pop_s) begin
                rd_d = rd_q + pop_adv_s;
            end else begin
                rd_d = rd_q;
            end
            count_d = count_q + (push_s ? push_cnt_s : CW'(0)) - (pop_s ? pop_cnt_s : CW'(0));
        end
    end

    // Queue storage and pointer registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                parcel_q[i] <= 16'h0000;
                pc_q[i]     <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            parcel_q <= parcel_d;
            pc_q     <= pc_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
        end
    end

    assign bus.fetch_ready = fetch_ready_s;
    assign bus.dec_ready   = dec_ready_s;
    assign bus.dec_pc      = dec_pc_s;
    assign bus.dec_instr   = dec_instr_s;
    assign bus.dec_npc     = dec_npc_s;
    assign bus.count       = count_q;

    fetch_align_queue_chk #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .CW    (CW)
    ) u_chk (
        .clock       (clock),
        .reset       (reset),
        .push        (push_s),
        .fetch_ready (fetch_ready_s),
        .count       (count_q),
        .wr          (wr_q),
        .rd          (rd_q)
    );
endmodule

// Occupancy consistency checks for the parcel queue.
module fetch_align_queue_chk #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CW    = 4
) (
    input logic          clock,
    input logic          reset,
    input logic          push,
    input logic          fetch_ready,
    input logic [CW-1:0] count,
    input logic [AW-1:0] wr,
    input logic [AW-1:0] rd
);
    logic [AW-1:0] diff_s;

    assign diff_s = wr - rd;

    // Sample occupancy invariants on every active edge outside reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (count <= CW'(DEPTH));
            assert (!push || fetch_ready);
            if (count == CW'(DEPTH)) begin
                assert (wr == rd);
            end else begin
                assert (count == {1'b0, diff_s});
            end
        end
    end
endmodule
